// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: per-cycle load/hold/bubble control for the 5-stage MIPS pipeline registers.
// Optional HAZARD_PERF_EN adds saturating hold_cycles / flush_count event counters.
module hazard_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       EX_memread,
    input  logic [4:0] EX_Rt,
    input  logic       MEM_memread,
    input  logic       MEM_memwrite,
    input  logic       MEM_branch_taken,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       EX_MEM_write,
    output logic       MEM_WB_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic       mem_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] hold_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       mem_access;
    logic       hold;
    logic       flush;
    logic       load_use;

    assign mem_access = MEM_memread | MEM_memwrite;
    assign load_use   = EX_memread && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
    assign flush      = MEM_branch_taken && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The release cycle (MWAIT, cnt==0) is not a hold and never re-arms on the same access.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_access && (MEM_WAIT != 0)) begin
                    hold      = 1'b1;
                    state_nxt = MWAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MWAIT: begin
                if (cnt != 4'd0) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        mem_busy     = 1'b0;
        if (rst) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (hold) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            mem_busy     = 1'b1;
        end else if (flush) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cycles <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (hold && (hold_cycles != 16'hFFFF)) begin
                hold_cycles <= hold_cycles + 16'd1;
            end
            if (flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`else
    // Event counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// tb_hazard_ctrl: two hazard_ctrl instances (MEM_WAIT=2 and 3) on shared stimulus,
// expected outputs queued by the driver and compared by an independent monitor.
module tb_hazard_ctrl;
    localparam int NL = 2;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID/ID_EX/EX_MEM flushes, mem_busy}
    localparam logic [8:0] RST_V   = 9'b00000_111_0;
    localparam logic [8:0] HOLD_V  = 9'b00000_000_1;
    localparam logic [8:0] FLUSH_V = 9'b11111_111_0;
    localparam logic [8:0] LU_V    = 9'b00111_010_0;
    localparam logic [8:0] NORM_V  = 9'b11111_000_0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ID_Rs = 5'd0, ID_Rt = 5'd0, EX_Rt = 5'd0;
    logic       EX_memread = 1'b0, MEM_memread = 1'b0, MEM_memwrite = 1'b0;
    logic       MEM_branch_taken = 1'b0;
    logic [8:0] out_v [NL];
`ifdef HAZARD_PERF_EN
    logic [15:0] hc [NL];
    logic [15:0] fc [NL];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        logic pw, ifw, idw, exw, mww, f_if, f_id, f_ex, mb;
        hazard_ctrl #(.MEM_WAIT((g == 0) ? 2 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
            .EX_memread(EX_memread), .EX_Rt(EX_Rt),
            .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
            .MEM_branch_taken(MEM_branch_taken),
            .PC_write(pw), .IF_ID_write(ifw), .ID_EX_write(idw),
            .EX_MEM_write(exw), .MEM_WB_write(mww),
            .IF_ID_flush(f_if), .ID_EX_flush(f_id), .EX_MEM_flush(f_ex),
            .mem_busy(mb)
`ifdef HAZARD_PERF_EN
            ,
            .hold_cycles(hc[g]), .flush_count(fc[g])
`endif
        );
        assign out_v[g] = {pw, ifw, idw, exw, mww, f_if, f_id, f_ex, mb};
    end

    // Reference model: remaining hold cycles of the current access and a pending release flag.
    int          rem  [NL];
    bit          rel  [NL];
    int          hcnt [NL];
    int          fcnt [NL];
    logic [17:0] sb [$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;

    task automatic model_reset(input int l);
        rem[l]  = 0;
        rel[l]  = 1'b0;
        hcnt[l] = 0;
        fcnt[l] = 0;
    endtask

    task automatic step(input int l, output logic [8:0] e);
        int w;
        bit acc, hold, lu;
        w    = (l == 0) ? 2 : 3;
        acc  = MEM_memread || MEM_memwrite;
        lu   = EX_memread && (EX_Rt != 5'd0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
        hold = 1'b0;
        if (rem[l] > 0) begin
            hold   = 1'b1;
            rem[l] = rem[l] - 1;
            rel[l] = (rem[l] == 0);
        end else if (rel[l]) begin
            rel[l] = 1'b0;
        end else if (acc && w > 0) begin
            hold   = 1'b1;
            rem[l] = w - 1;
            rel[l] = (rem[l] == 0);
        end
        if (hold) begin
            e = HOLD_V;
            hcnt[l]++;
        end else if (MEM_branch_taken) begin
            e = FLUSH_V;
            fcnt[l]++;
        end else if (lu) begin
            e = LU_V;
        end else begin
            e = NORM_V;
        end
    endtask

    // pulse: rst rises mid-cycle and falls before the next clock edge.
    task automatic cycle(input logic r, input logic pulse,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                         input logic emr, input logic mr, input logic mw, input logic bt);
        logic [8:0] e [NL];
        logic [8:0] dummy;
        @(negedge clk);
        cyc++;
        ID_Rs = rs; ID_Rt = rt; EX_Rt = ert;
        EX_memread = emr; MEM_memread = mr; MEM_memwrite = mw; MEM_branch_taken = bt;
        rst = r | pulse;
        for (int l = 0; l < NL; l++) begin
            if (r || pulse) begin
                e[l] = RST_V;
                model_reset(l);
            end else begin
                step(l, e[l]);
            end
        end
        sb.push_back({e[1], e[0]});
        if (pulse) begin
            #4;
            rst = 1'b0;
            for (int l = 0; l < NL; l++) step(l, dummy);
        end
    endtask

    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int l = 0; l < NL; l++) begin
                    checks++;
                    if (out_v[l] !== e[l*9 +: 9]) begin
                        fails++;
                        $display("FAIL outputs lane%0d cycle%0d got %b expected %b",
                                 l, cyc, out_v[l], e[l*9 +: 9]);
                    end
                end
            end
        end
    end

    initial begin : driver
        // reset, then load-use stall followed by normal flow
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 2, 5, 2, 1, 0, 0, 0);
        cycle(0, 0, 2, 5, 7, 0, 0, 0, 0);
        // load into $0 never stalls
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 4, 3, 3, 1, 0, 0, 0);
        // memory read held constant: holds, release, re-hold for the next access
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // branch taken together with a load-use match: flush wins
        cycle(0, 0, 3, 1, 3, 1, 0, 0, 1);
        // store hold interrupted by an asynchronous reset pulse
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
        end
        // three MEM_WAIT=2 accesses and one branch flush after a clean reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
`ifdef HAZARD_PERF_EN
        for (int l = 0; l < NL; l++) begin
            checks++;
            if (int'(hc[l]) != hcnt[l]) begin
                fails++;
                $display("FAIL hold_cycles lane%0d got %0d expected %0d", l, hc[l], hcnt[l]);
            end
            checks++;
            if (int'(fc[l]) != fcnt[l]) begin
                fails++;
                $display("FAIL flush_count lane%0d got %0d expected %0d", l, fc[l], fcnt[l]);
            end
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether each stage register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) loads, holds or takes a bubble. It handles three hazard sources:
- multi-cycle data-memory waits;
- taken branches resolved in MEM;
- load-use hazards between the EX and ID stages.

It drives the write-enable and flush inputs of all pipeline registers.

## Interface
Parameters:
- MEM_WAIT, default 2: hold cycles per data-memory access in MEM; 0 disables memory holds; legal 0..15.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- EX_memread  in  1  instruction in EX is a load.
- EX_Rt  in  5  destination of the instruction in EX.
- MEM_memread  in  1  instruction in MEM reads data memory.
- MEM_memwrite  in  1  instruction in MEM writes data memory.
- MEM_branch_taken  in  1  branch in MEM is taken (branch & zero).
- PC_write  out  1  PC loads its next value.
- IF_ID_write  out  1  IF_ID loads.
- ID_EX_write  out  1  ID_EX loads.
- EX_MEM_write  out  1  EX_MEM loads.
- MEM_WB_write  out  1  MEM_WB loads.
- IF_ID_flush  out  1  IF_ID loads a NOP.
- ID_EX_flush  out  1  ID_EX loads all-zero control fields.
- EX_MEM_flush  out  1  EX_MEM loads all-zero control fields.
- mem_busy  out  1  a memory hold is in progress.

Downstream rule: in every pipeline register, a flush input overrides its write input.

## Operation
- State register holds RUN or MWAIT, plus a 4-bit down-counter `cnt`.
- Outputs are combinational from state, `cnt` and the current inputs.
- Priority each cycle: rst > HOLD > FLUSH > LOADUSE > NORMAL.
- HOLD applies when either condition is true:
  - state RUN, (MEM_memread | MEM_memwrite), and MEM_WAIT ≠ 0;
  - state MWAIT and cnt ≠ 0.
- HOLD outputs: all five *_write = 0, all flushes = 0, mem_busy = 1.
- FLUSH (MEM_branch_taken and not HOLD) outputs:
  - all *_write = 1;
  - IF_ID_flush = ID_EX_flush = EX_MEM_flush = 1.
  - Load-use detection is suppressed, because the ID instruction is squashed.
- LOADUSE (EX_memread & EX_Rt ≠ 0 & (EX_Rt == ID_Rs | EX_Rt == ID_Rt), not HOLD/FLUSH) outputs:
  - PC_write = IF_ID_write = 0;
  - ID_EX_flush = 1;
  - ID_EX_write = EX_MEM_write = MEM_WB_write = 1;
  - other flushes = 0.
- NORMAL outputs: all *_write = 1, all flushes = 0, mem_busy = 0.
- Transitions:
  - RUN with a memory access and MEM_WAIT ≠ 0 → MWAIT, cnt ← MEM_WAIT−1.
  - MWAIT with cnt ≠ 0 → MWAIT, cnt ← cnt−1.
  - MWAIT with cnt == 0 → RUN. This is the release cycle: HOLD is not asserted, the access completes and the pipeline advances.
  - A memory access in MEM during the release cycle does not re-trigger a hold; it is the same instruction.
- Inputs that would cause FLUSH or LOADUSE during HOLD are ignored. They are re-evaluated once the hold releases, since the frozen pipeline presents the same inputs.

## Timing
- Reset (asynchronous):
  - state ← RUN, cnt ← 0;
  - while rst = 1, all *_write = 0, all flushes = 1, mem_busy = 0.
- Deassertion of rst takes effect at the next rising edge of clk; there is no extra latency.
- Load-use stall: exactly 1 cycle per hazard. The load has moved to MEM on the following cycle.
- Memory access: exactly MEM_WAIT hold cycles, then 1 release cycle; access-to-advance latency is MEM_WAIT+1 cycles.
- Branch flush: 1 cycle; the PC loads the target on the same edge.
- Reset mid-MWAIT: the counter is discarded and the pipeline is flushed.

## Configuration
- HAZARD_PERF_EN, when defined, adds two ports:
  - hold_cycles  out  16: increments each HOLD cycle.
  - flush_count  out  16: increments each FLUSH cycle.
- Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When HAZARD_PERF_EN is undefined, the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- lw $2 in EX (EX_memread = 1, EX_Rt = 2), ID_Rs = 2 → one cycle with PC_write = 0, IF_ID_write = 0, ID_EX_flush = 1; NORMAL the next cycle.
- EX_memread = 1, EX_Rt = 0, ID_Rs = 0 → no stall, all *_write = 1.
- MEM_WAIT = 2, MEM_memread = 1 held constant from RUN → HOLD for 2 cycles (mem_busy = 1), release on cycle 3, back to RUN.
- MEM_branch_taken = 1 together with a load-use match → FLUSH only: three flushes = 1, PC_write = 1.
- MEM_WAIT = 3, MEM_memwrite = 1; assert rst after 1 hold cycle → outputs immediately show reset values; after release, state is RUN and cnt = 0.
- HAZARD_PERF_EN defined: 3 holds of MEM_WAIT = 2 plus 1 flush → hold_cycles = 6, flush_count = 1.
